// File: rtl/demux_comparador.sv
// Compare/select demux: routes each accepted word to one of two one-entry output channels.
// Optional per-channel delivery counters are enabled by defining DEMUX_COUNT_EN.
module demux_comparador #(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 in_clk,
  input  logic                 in_reset,
  input  logic                 in_valid,
  output logic                 out_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [WIDTH-1:0]     in_key,
  input  logic                 in_select,
  output logic                 out_valid_0,
  input  logic                 in_ready_0,
  output logic [WIDTH-1:0]     out_data_0,
  output logic                 out_valid_1,
  input  logic                 in_ready_1,
  output logic [WIDTH-1:0]     out_data_1,
  output logic [CNT_WIDTH-1:0] out_cnt_0,
  output logic [CNT_WIDTH-1:0] out_cnt_1
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_e;

  ch_state_e        state0_q, state0_d, state1_q, state1_d;
  logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic             accept, match, dest, load0, load1;

  assign out_valid_0 = (state0_q == FULL);
  assign out_valid_1 = (state1_q == FULL);
  assign out_data_0  = data0_q;
  assign out_data_1  = data1_q;

  // A channel can take a word if it is empty or being drained this cycle.
  assign out_ready = (!out_valid_0 | in_ready_0) & (!out_valid_1 | in_ready_1);
  assign accept    = in_valid & out_ready;
  assign match     = (in_data == in_key);
  assign dest      = match ? in_select : ~in_select;
  assign load0     = accept & ~dest;
  assign load1     = accept & dest;

  always_comb begin
    state0_d = state0_q;
    data0_d  = data0_q;
    unique case (state0_q)
      EMPTY: if (load0) begin
        state0_d = FULL;
        data0_d  = in_data;
      end
      FULL: if (load0) begin
        data0_d = in_data;
      end else if (in_ready_0) begin
        state0_d = EMPTY;
      end
      default: state0_d = EMPTY;
    endcase
  end

  always_comb begin
    state1_d = state1_q;
    data1_d  = data1_q;
    unique case (state1_q)
      EMPTY: if (load1) begin
        state1_d = FULL;
        data1_d  = in_data;
      end
      FULL: if (load1) begin
        data1_d = in_data;
      end else if (in_ready_1) begin
        state1_d = EMPTY;
      end
      default: state1_d = EMPTY;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state0_q <= EMPTY;
      state1_q <= EMPTY;
      data0_q  <= '0;
      data1_q  <= '0;
    end else begin
      state0_q <= state0_d;
      state1_q <= state1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Count deliveries, saturating at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (out_valid_0 && in_ready_0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_WIDTH'(1);
    if (out_valid_1 && in_ready_1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign out_cnt_0 = cnt0_q;
  assign out_cnt_1 = cnt1_q;
`else
  assign out_cnt_0 = '0;
  assign out_cnt_1 = '0;
`endif

endmodule
